// File: rtl/trace_pkg.sv
// Purpose: shared constants, pointer-width helper and FIFO status type for the trace capture block.
// Latency: none (declarations only).
// Backpressure: n/a. The optional TRACE_DROP_COUNT_EN build uses DROP_CNT_W/DROP_CNT_MAX.
package trace_pkg;

   localparam int DROP_CNT_W   = 8;
   localparam int DROP_CNT_MAX = 255;

   // Pointer width: index bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
   } fifo_status_t;

endpackage

// File: rtl/trace_capture_fifo_if.sv
// Purpose: sample/handshake bundle between the trace capture FIFO and the display monitor.
// Latency: none (wires only).
// Backpressure: monitor drives ready; the FIFO holds O/valid until ready is seen at an edge.
interface trace_capture_fifo_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] O;
   logic             valid;
   logic             ready;
   logic             full;
   logic             empty;

   modport master (output O, output valid, output full, output empty, input ready);
   modport slave  (input O, input valid, input full, input empty, output ready);
endinterface

// File: rtl/trace_fifo.sv
// Purpose: first-word fall-through sample store with wrap-bit pointers and full/empty status.
// Latency: a pushed word is visible at head_dat_o one cycle after the push edge.
// Backpressure: caller gates push_i on full (or same-cycle pop); pop_i must only be asserted when non-empty.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output fifo_status_t     status_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Advance pointers; the extra MSB wraps naturally modulo 2*DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push_i);
      rd_ptr_d = rd_ptr_q + PW'(pop_i);
   end

   // Pointer registers.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is cleared on reset so the head never shows X, even when empty.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

   assign head_dat_o     = mem_q[rd_ptr_q[AW-1:0]];
   assign status_o.empty = (wr_ptr_q == rd_ptr_q);
   assign status_o.full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

endmodule

// File: rtl/trace_capture_fifo.sv
// Purpose: change-detecting sampler feeding a small FWFT FIFO; TRACE_DROP_COUNT_EN adds a saturating drop counter.
// Latency: a sample captured at edge k is presented with valid=1 right after edge k (1 cycle).
// Backpressure: monitor stalls via ready; when full with no pop, new samples are dropped, stored entries are kept.
module trace_capture_fifo
   import trace_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  ASYNCRESETN,
   input  logic [WIDTH-1:0]      I,
   input  logic                  en,
   trace_capture_fifo_if.master  mon
`ifdef TRACE_DROP_COUNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_count
`endif
);

   logic [WIDTH-1:0] prev_q, prev_d;
   logic             first_q, first_d;
   logic             capture, push, pop;
   logic [WIDTH-1:0] head_dat;
   fifo_status_t     status;

   // Capture on enable when the value moved, or unconditionally for the first sample after reset.
   always_comb begin
      capture = en && (first_q || (I != prev_q));
      pop     = !status.empty && mon.ready;
      push    = capture && (!status.full || pop);
      prev_d  = capture ? I : prev_q;
      first_d = capture ? 1'b0 : first_q;
   end

   // Change-detect state tracks the last captured value, whether or not it was stored.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         prev_q  <= '0;
         first_q <= 1'b1;
      end else begin
         prev_q  <= prev_d;
         first_q <= first_d;
      end
   end

   trace_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .CLK        (CLK),
      .ASYNCRESETN(ASYNCRESETN),
      .push_i     (push),
      .push_dat_i (I),
      .pop_i      (pop),
      .head_dat_o (head_dat),
      .status_o   (status)
   );

   assign mon.O     = head_dat;
   assign mon.valid = !status.empty;
   assign mon.full  = status.full;
   assign mon.empty = status.empty;

`ifdef TRACE_DROP_COUNT_EN
   logic                  drop;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Count discarded samples, holding at the maximum rather than wrapping.
   always_comb begin
      drop       = capture && status.full && !pop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != DROP_CNT_W'(DROP_CNT_MAX))) drop_cnt_d = drop_cnt_q + 1'b1;
   end

   // Drop counter register, cleared only by reset.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) drop_cnt_q <= '0;
      else              drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Purpose: directed and randomized bench for trace_capture_fifo against a queue-based reference.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: ready is driven directly on the monitor interface; TRACE_DROP_COUNT_EN enables drop_count checks.
module tb_trace_capture_fifo;
   import trace_pkg::*;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

   logic             CLK = 1'b0;
   logic             ASYNCRESETN;
   logic             en;
   logic [WIDTH-1:0] I;

   trace_capture_fifo_if #(.WIDTH(WIDTH)) mon ();

`ifdef TRACE_DROP_COUNT_EN
   logic [DROP_CNT_W-1:0] drop_count;
`endif

   trace_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .ASYNCRESETN(ASYNCRESETN),
      .I          (I),
      .en         (en),
      .mon        (mon)
`ifdef TRACE_DROP_COUNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   always #5 CLK = ~CLK;

   // Reference: a plain queue of printed samples plus last-captured value.
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_prev;
   bit               m_first;
   int               m_drops;

   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      q.delete();
      m_prev  = '0;
      m_first = 1'b1;
      m_drops = 0;
   endtask

   // One clock edge of the intended behaviour, using inputs as they stood at the edge.
   task automatic model_edge();
      logic [WIDTH-1:0] tmp;
      bit pop, cap, was_full;
      pop      = (q.size() > 0) && (mon.ready === 1'b1);
      cap      = en && (m_first || (I != m_prev));
      was_full = (q.size() == DEPTH);
      if (pop) tmp = q.pop_front();
      if (cap) begin
         m_prev  = I;
         m_first = 1'b0;
         if (!was_full || pop) q.push_back(I);
         else if (m_drops < 255) m_drops++;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, mon.valid, (q.size() > 0));
      check({tag, ".empty"}, mon.empty, (q.size() == 0));
      check({tag, ".full"},  mon.full,  (q.size() == DEPTH));
      if (q.size() > 0) check({tag, ".O"}, mon.O, q[0]);
      else              check({tag, ".O_known"}, $isunknown(mon.O), 0);
`ifdef TRACE_DROP_COUNT_EN
      check({tag, ".drop_count"}, drop_count, m_drops);
`endif
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      // Reset state
      ASYNCRESETN = 1'b0;
      en          = 1'b0;
      I           = '0;
      mon.ready   = 1'b0;
      model_reset();
      #1;
      check("rst.valid", mon.valid, 0);
      check("rst.empty", mon.empty, 1);
      check("rst.full",  mon.full,  0);
      check("rst.O",     mon.O,     0);
`ifdef TRACE_DROP_COUNT_EN
      check("rst.drop_count", drop_count, 0);
`endif
      repeat (2) @(negedge CLK);
      ASYNCRESETN = 1'b1;

      // First sample captured unconditionally, then nothing while I holds
      en = 1'b1;
      I  = '0;
      step("first");
      check("first.O_is_0", mon.O, 0);
      check("first.valid",  mon.valid, 1);
      repeat (3) step("hold");
      mon.ready = 1'b1;
      step("drain0");
      check("drain0.empty", mon.empty, 1);

      // Back-to-back toggles with ready held high
      I = 4'd1; step("tog1");
      check("tog1.O", mon.O, 1);
      I = 4'd0; step("tog0");
      check("tog0.O", mon.O, 0);
      I = 4'd1; step("tog1b");
      check("tog1b.O", mon.O, 1);
      step("tog_end");

      // Six changes while stalled: four stored, two dropped
      mon.ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         I = WIDTH'(k + 2);
         step("stall");
      end
      check("stall.full", mon.full, 1);
      check("stall.head", mon.O, 2);
`ifdef TRACE_DROP_COUNT_EN
      check("stall.drops", drop_count, 2);
`endif
      mon.ready = 1'b1;
      repeat (5) step("drain_stall");

      // Full + pop + new change in the same cycle: accepted, still full
      mon.ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         I = WIDTH'(k + 8);
         step("refill");
      end
      mon.ready = 1'b1;
      I = 4'd12;
      step("full_pop_push");
      check("fpp.full", mon.full, 1);
      check("fpp.head", mon.O, 9);
      repeat (5) step("drain_fpp");

      // en low blocks capture; en high with I==prev does nothing; change captures once
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         I = WIDTH'(k[0] ? 4'd3 : 4'd5);
         step("en_off");
      end
      check("en_off.empty", mon.empty, 1);
      en = 1'b1;
      I  = 4'd12;
      step("en_same");
      check("en_same.empty", mon.empty, 1);
      mon.ready = 1'b0;
      I = 4'd6;
      step("en_diff");
      check("en_diff.O", mon.O, 6);
      repeat (2) step("en_hold");

      // Reset mid-cycle with three entries stored
      mon.ready = 1'b1;
      step("pre_rst_drain");
      mon.ready = 1'b0;
      I = 4'd5; step("fill3");
      I = 4'd6; step("fill3");
      I = 4'd7; step("fill3");
      #3;
      ASYNCRESETN = 1'b0;
      #1;
      check("midrst.valid", mon.valid, 0);
      check("midrst.empty", mon.empty, 1);
      model_reset();
      check_outputs("midrst");
      @(negedge CLK);
      ASYNCRESETN = 1'b1;
      I = '0;
      step("post_rst");
      check("post_rst.O",     mon.O, 0);
      check("post_rst.valid", mon.valid, 1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         en        = ($urandom_range(0, 3) != 0);
         mon.ready = ($urandom_range(0, 2) == 0);
         I         = WIDTH'($urandom_range(0, 3));
         step("rand");
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
